// File: rtl/gdo_pkg.sv
// Signed fixed-point word arithmetic (gdo format): 16-bit words with gdo_size fraction bits,
// saturating add and multiply.
package gdo;

  localparam int gdo_size  = 8;
  localparam int gdo_width = 16;

  function automatic logic signed [15:0] gdo_sat(input logic signed [31:0] v);
    if (v > 32'sd32767) return 16'sh7fff;
    if (v < -32'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

  function automatic logic signed [15:0] gdo_add(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [31:0] s;
    s = 32'(a) + 32'(b);
    return gdo_sat(s);
  endfunction

  // Product is floored (arithmetic shift) before saturation.
  function automatic logic signed [15:0] gdo_mult(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    p = p >>> gdo_size;
    return gdo_sat(p);
  endfunction

endpackage

// File: rtl/wu_pkg.sv
// Shared types and row packing helpers for the weight update sequencer.
// Word c of a row lives at [(size-c)*data_size-1 -: data_size].
package wu_pkg;

  localparam int unsigned WuDataSize     = 16;
  localparam int unsigned WuSize         = 3;
  localparam int unsigned WuMaxLayerSize = 4;
  localparam int unsigned WuRowBits      = WuDataSize * WuSize;

  typedef enum logic [1:0] {IDLE, REQ, CAP, FIN} wu_state_t;

  typedef logic [WuDataSize-1:0] word_t;
  typedef logic [WuSize-1:0][WuDataSize-1:0] row_words_t;

  function automatic row_words_t unpack_row(input logic [WuRowBits-1:0] row);
    row_words_t w;
    for (int c = 0; c < int'(WuSize); c++) begin
      w[c] = row[(int'(WuSize) - c) * int'(WuDataSize) - 1 -: WuDataSize];
    end
    return w;
  endfunction

  function automatic logic [WuRowBits-1:0] pack_row(input row_words_t w);
    logic [WuRowBits-1:0] row;
    row = '0;
    for (int c = 0; c < int'(WuSize); c++) begin
      row[(int'(WuSize) - c) * int'(WuDataSize) - 1 -: WuDataSize] = w[c];
    end
    return row;
  endfunction

  // Negation that maps the most-negative word to +max instead of wrapping.
  function automatic word_t neg_sat(input word_t v);
    if (v == {1'b1, {(WuDataSize - 1){1'b0}}}) return {1'b0, {(WuDataSize - 1){1'b1}}};
    return -v;
  endfunction

endpackage

// File: rtl/weight_bank.sv
// Weight storage: [max_layer_size][size] rows, one write port, a forward read port and an
// update read tap addressed by the sequencer. Out-of-range writes drop, reads return 0.
module weight_bank #(
  parameter int unsigned data_size      = 16,
  parameter int unsigned size           = 3,
  parameter int unsigned max_layer_size = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [31:0]                 wr_layer,
  input  logic [31:0]                 wr_row,
  input  logic [data_size*size-1:0]   wr_data,
  input  logic [31:0]                 rd_layer,
  input  logic [31:0]                 rd_row,
  output logic [data_size*size-1:0]   rd_data,
  input  logic [31:0]                 upd_layer,
  input  logic [31:0]                 upd_row,
  output logic [data_size*size-1:0]   upd_data
);

  localparam int unsigned LayerW = (max_layer_size > 1) ? $clog2(max_layer_size) : 1;
  localparam int unsigned RowW   = (size > 1) ? $clog2(size) : 1;

  logic [data_size*size-1:0] mem [max_layer_size][size];

  function automatic logic in_range(input logic [31:0] l, input logic [31:0] r);
    return (l < max_layer_size) && (r < size);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < int'(max_layer_size); l++) begin
        for (int r = 0; r < int'(size); r++) begin
          mem[l][r] <= '0;
        end
      end
    end else if (wr_en && in_range(wr_layer, wr_row)) begin
      mem[wr_layer[LayerW-1:0]][wr_row[RowW-1:0]] <= wr_data;
    end
  end

  assign rd_data  = in_range(rd_layer, rd_row)   ? mem[rd_layer[LayerW-1:0]][rd_row[RowW-1:0]]
                                                 : '0;
  assign upd_data = in_range(upd_layer, upd_row) ? mem[upd_layer[LayerW-1:0]][upd_row[RowW-1:0]]
                                                 : '0;

endmodule

// File: rtl/weight_update_sequencer.sv
// Walks every (layer,row), requests its gradient row from the backprop stack and applies
// w_new = w - lr*g into the local weight bank.
module weight_update_sequencer
  import wu_pkg::*;
  import gdo::*;
#(
  parameter int unsigned data_size      = WuDataSize,
  parameter int unsigned size           = WuSize,
  parameter int unsigned max_layer_size = WuMaxLayerSize
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [31:0]                 num_layers,
  input  logic [data_size-1:0]        learning_rate,
  output logic                        busy,
  output logic                        done,
  output logic                        cal_dc_dw,
  output logic [31:0]                 dc_dw_layer,
  output logic [31:0]                 dc_dw_row,
  input  logic [data_size*size-1:0]   dc_dw_stream,
  input  logic                        load_en,
  input  logic [31:0]                 load_layer,
  input  logic [31:0]                 load_row,
  input  logic [data_size*size-1:0]   load_data,
  input  logic [31:0]                 weight_rd_layer,
  input  logic [31:0]                 weight_rd_row,
  output logic [data_size*size-1:0]   weight_rd_data
);

  localparam int unsigned RowBits = data_size * size;
  localparam logic [31:0] LastRow = 32'(size - 1);
  localparam logic [31:0] MaxN    = 32'(max_layer_size);

  wu_state_t   state_q, state_d;
  logic [31:0] layer_q, layer_d;
  logic [31:0] row_q, row_d;
  logic [31:0] n_q, n_d;
  word_t       neg_lr_q, neg_lr_d;

  logic               wr_en;
  logic [31:0]        wr_layer, wr_row;
  logic [RowBits-1:0] wr_data, cur_row, upd_row;
  row_words_t         cur_w, grad_w, new_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      layer_q  <= '0;
      row_q    <= '0;
      n_q      <= '0;
      neg_lr_q <= '0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      row_q    <= row_d;
      n_q      <= n_d;
      neg_lr_q <= neg_lr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    row_d       = row_q;
    n_d         = n_q;
    neg_lr_d    = neg_lr_q;
    busy        = 1'b0;
    done        = 1'b0;
    cal_dc_dw   = 1'b0;
    dc_dw_layer = '0;
    dc_dw_row   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d      = (num_layers > MaxN) ? MaxN : num_layers;
          neg_lr_d = neg_sat(learning_rate);
          layer_d  = '0;
          row_d    = '0;
          state_d  = (n_d == '0) ? FIN : REQ;
        end
      end
      REQ: begin
        busy        = 1'b1;
        cal_dc_dw   = 1'b1;
        dc_dw_layer = layer_q;
        dc_dw_row   = row_q;
        state_d     = CAP;
      end
      CAP: begin
        busy = 1'b1;
        if (row_q == LastRow) begin
          row_d   = '0;
          layer_d = layer_q + 32'd1;
        end else begin
          row_d = row_q + 32'd1;
        end
        state_d = (layer_q == n_q - 32'd1 && row_q == LastRow) ? FIN : REQ;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Update datapath: stream holds the response to the REQ of the previous cycle.
  always_comb begin
    cur_w  = unpack_row(cur_row);
    grad_w = unpack_row(dc_dw_stream);
    new_w  = '0;
    for (int c = 0; c < int'(size); c++) begin
      new_w[c] = gdo_add(cur_w[c], gdo_mult(neg_lr_q, grad_w[c]));
    end
    upd_row = pack_row(new_w);
  end

  // Preload never collides with an update: it is only honoured while not busy.
  assign wr_en    = (state_q == CAP) || (load_en && !busy);
  assign wr_layer = (state_q == CAP) ? layer_q : load_layer;
  assign wr_row   = (state_q == CAP) ? row_q   : load_row;
  assign wr_data  = (state_q == CAP) ? upd_row : load_data;

  weight_bank #(
    .data_size      (data_size),
    .size           (size),
    .max_layer_size (max_layer_size)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_layer  (wr_layer),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .rd_layer  (weight_rd_layer),
    .rd_row    (weight_rd_row),
    .rd_data   (weight_rd_data),
    .upd_layer (layer_q),
    .upd_row   (row_q),
    .upd_data  (cur_row)
  );

endmodule

// File: tb/tb_weight_update_sequencer.sv
// Scoreboard bench for weight_update_sequencer: request order, pass timing, bank contents.
module tb_weight_update_sequencer;

  localparam int ML  = 4;
  localparam int SZ  = 3;
  localparam int ONE = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] num_layers = '0;
  logic [15:0] learning_rate = '0;
  logic        busy, done, cal_dc_dw;
  logic [31:0] dc_dw_layer, dc_dw_row;
  logic [47:0] dc_dw_stream = '0;
  logic        load_en = 1'b0;
  logic [31:0] load_layer = '0, load_row = '0;
  logic [47:0] load_data = '0;
  logic [31:0] weight_rd_layer = '0, weight_rd_row = '0;
  logic [47:0] weight_rd_data;

  int total = 0;
  int bad = 0;
  int mw[ML][SZ][SZ];
  int grad[ML][SZ][SZ];
  int exp_l[$];
  int exp_r[$];

  weight_update_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .num_layers      (num_layers),
    .learning_rate   (learning_rate),
    .busy            (busy),
    .done            (done),
    .cal_dc_dw       (cal_dc_dw),
    .dc_dw_layer     (dc_dw_layer),
    .dc_dw_row       (dc_dw_row),
    .dc_dw_stream    (dc_dw_stream),
    .load_en         (load_en),
    .load_layer      (load_layer),
    .load_row        (load_row),
    .load_data       (load_data),
    .weight_rd_layer (weight_rd_layer),
    .weight_rd_row   (weight_rd_row),
    .weight_rd_data  (weight_rd_data)
  );

  always #5 clk = ~clk;

  function automatic int sat16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int tb_mult(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return sat16(p >>> 8);
  endfunction

  function automatic int tb_neg(int lr);
    return (lr == -32768) ? 32767 : -lr;
  endfunction

  function automatic logic [47:0] tb_pack(int a, int b, int c);
    return {16'(a), 16'(b), 16'(c)};
  endfunction

  function automatic logic [47:0] exp_row(int l, int r);
    return tb_pack(mw[l][r][0], mw[l][r][1], mw[l][r][2]);
  endfunction

  // Backprop stack model: registered response to each request.
  always @(posedge clk) begin
    if (cal_dc_dw && dc_dw_layer < ML && dc_dw_row < SZ)
      dc_dw_stream <= tb_pack(grad[dc_dw_layer][dc_dw_row][0], grad[dc_dw_layer][dc_dw_row][1],
                              grad[dc_dw_layer][dc_dw_row][2]);
  end

  task automatic model_clear();
    for (int l = 0; l < ML; l++)
      for (int r = 0; r < SZ; r++)
        for (int c = 0; c < SZ; c++) begin
          mw[l][r][c] = 0;
          grad[l][r][c] = 0;
        end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic preload(int l, int r, int a, int b, int c);
    @(negedge clk);
    load_en = 1'b1; load_layer = l; load_row = r; load_data = tb_pack(a, b, c);
    @(negedge clk);
    load_en = 1'b0;
    if (l < ML && r < SZ) begin
      mw[l][r][0] = a; mw[l][r][1] = b; mw[l][r][2] = c;
    end
  endtask

  // Runs one pass; requests are compared against the scoreboard as they appear.
  task automatic run_pass(input int n, input int lr, input bit disturb, output int k,
                          output int cal_cnt, output int busy_cnt, output bit alt_bad);
    int  nn;
    bit  prev_cal, got_done;
    nn = (n > ML) ? ML : n;
    for (int l = 0; l < nn; l++)
      for (int r = 0; r < SZ; r++) begin
        exp_l.push_back(l);
        exp_r.push_back(r);
        for (int c = 0; c < SZ; c++)
          mw[l][r][c] = sat16(longint'(mw[l][r][c]) + tb_mult(tb_neg(lr), grad[l][r][c]));
      end
    k = 0; cal_cnt = 0; busy_cnt = 0; alt_bad = 0; prev_cal = 0; got_done = 0;
    @(negedge clk);
    start = 1'b1; num_layers = n; learning_rate = 16'(lr);
    while (!got_done && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (cal_dc_dw) begin
        cal_cnt++;
        if (prev_cal) alt_bad = 1;
        total++;
        if (exp_l.size() == 0) begin
          bad++;
          $display("FAIL req_extra got=(%0d,%0d) want=none", dc_dw_layer, dc_dw_row);
        end else begin
          int el, er;
          el = exp_l.pop_front();
          er = exp_r.pop_front();
          if (dc_dw_layer !== 32'(el) || dc_dw_row !== 32'(er)) begin
            bad++;
            $display("FAIL req_order got=(%0d,%0d) want=(%0d,%0d)", dc_dw_layer, dc_dw_row,
                     el, er);
          end
        end
      end
      if (done) begin
        got_done = 1;
        if (cal_dc_dw) alt_bad = 1;
      end
      prev_cal = cal_dc_dw;
      if (disturb && k == 3) begin
        start = 1'b1; num_layers = 4; load_en = 1'b1; load_layer = 2; load_row = 0;
        load_data = tb_pack(7, 7, 7);
      end
      if (disturb && k == 4) begin
        start = 1'b0; load_en = 1'b0;
      end
    end
    total++;
    if (!got_done) begin
      bad++;
      $display("FAIL done_timeout got=no_done want=done");
    end
    total++;
    if (exp_l.size() != 0) begin
      bad++;
      $display("FAIL req_missing got=%0d_left want=0", exp_l.size());
    end
    exp_l.delete();
    exp_r.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, cal_dc_dw} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000", {busy, done, cal_dc_dw});
    end
    total++;
    if (dc_dw_layer !== 32'd0 || dc_dw_row !== 32'd0) begin
      bad++;
      $display("FAIL reset_idx got=(%0d,%0d) want=(0,0)", dc_dw_layer, dc_dw_row);
    end
    reset = 1'b0;
    model_clear();
    for (int l = 0; l < ML; l++)
      for (int r = 0; r < SZ; r++) begin
        weight_rd_layer = l; weight_rd_row = r; #1;
        total++;
        if (weight_rd_data !== 48'd0) begin
          bad++;
          $display("FAIL reset_bank L%0dR%0d got=%h want=0", l, r, weight_rd_data);
        end
      end
  endtask

  task automatic test_single_row();
    int k, cc, bc;
    bit ab;
    preload(0, 0, 10 * ONE, 20 * ONE, 30 * ONE);
    grad[0][0][0] = ONE; grad[0][0][1] = 2 * ONE; grad[0][0][2] = 3 * ONE;
    run_pass(1, ONE, 0, k, cc, bc, ab);
    total++;
    if (k != 7) begin
      bad++;
      $display("FAIL single_done_cycle got=%0d want=7", k);
    end
    weight_rd_layer = 0; weight_rd_row = 0; #1;
    total++;
    if (weight_rd_data !== tb_pack(9 * ONE, 18 * ONE, 27 * ONE)) begin
      bad++;
      $display("FAIL single_update got=%h want=%h", weight_rd_data,
               tb_pack(9 * ONE, 18 * ONE, 27 * ONE));
    end
  endtask

  task automatic test_two_layers();
    int k, cc, bc;
    bit ab;
    do_reset();
    for (int l = 0; l < 2; l++)
      for (int r = 0; r < SZ; r++) begin
        preload(l, r, (l * 10 + r) * ONE, ONE, -ONE);
        for (int c = 0; c < SZ; c++) grad[l][r][c] = (l + r + c + 1) * ONE;
      end
    run_pass(2, ONE / 4, 0, k, cc, bc, ab);
    total++;
    if (k != 13 || bc != 12 || cc != 6 || ab) begin
      bad++;
      $display("FAIL two_layer_timing got=k%0d busy%0d cal%0d alt%0d want=k13 busy12 cal6 alt0",
               k, bc, cc, ab);
    end
    for (int l = 0; l < ML; l++)
      for (int r = 0; r < SZ; r++) begin
        weight_rd_layer = l; weight_rd_row = r; #1;
        total++;
        if (weight_rd_data !== exp_row(l, r)) begin
          bad++;
          $display("FAIL two_layer_bank L%0dR%0d got=%h want=%h", l, r, weight_rd_data,
                   exp_row(l, r));
        end
      end
  endtask

  task automatic test_layer_bounds();
    int k, cc, bc;
    bit ab;
    do_reset();
    preload(0, 1, ONE, 2 * ONE, 3 * ONE);
    grad[0][1][0] = ONE;
    run_pass(0, ONE, 0, k, cc, bc, ab);
    total++;
    if (k != 1 || cc != 0 || bc != 0) begin
      bad++;
      $display("FAIL zero_layers got=k%0d cal%0d busy%0d want=k1 cal0 busy0", k, cc, bc);
    end
    weight_rd_layer = 0; weight_rd_row = 1; #1;
    total++;
    if (weight_rd_data !== tb_pack(ONE, 2 * ONE, 3 * ONE)) begin
      bad++;
      $display("FAIL zero_layers_bank got=%h want=%h", weight_rd_data,
               tb_pack(ONE, 2 * ONE, 3 * ONE));
    end
    for (int l = 0; l < ML; l++)
      for (int r = 0; r < SZ; r++) grad[l][r][l % SZ] = -(r + 1) * ONE;
    run_pass(9, ONE / 2, 0, k, cc, bc, ab);
    total++;
    if (k != 25 || cc != 12 || bc != 24 || ab) begin
      bad++;
      $display("FAIL clamp_layers got=k%0d cal%0d busy%0d want=k25 cal12 busy24", k, cc, bc);
    end
    for (int l = 0; l < ML; l++)
      for (int r = 0; r < SZ; r++) begin
        weight_rd_layer = l; weight_rd_row = r; #1;
        total++;
        if (weight_rd_data !== exp_row(l, r)) begin
          bad++;
          $display("FAIL clamp_bank L%0dR%0d got=%h want=%h", l, r, weight_rd_data,
                   exp_row(l, r));
        end
      end
  endtask

  task automatic test_ignored_inputs();
    int k, cc, bc;
    bit ab;
    do_reset();
    preload(0, 0, ONE, 2 * ONE, 3 * ONE);
    preload(1, 0, 4 * ONE, 5 * ONE, 6 * ONE);
    grad[0][0][0] = ONE; grad[0][0][1] = ONE; grad[0][0][2] = ONE;
    run_pass(1, ONE, 1, k, cc, bc, ab);
    total++;
    if (k != 7 || cc != 3) begin
      bad++;
      $display("FAIL start_while_busy got=k%0d cal%0d want=k7 cal3", k, cc);
    end
    preload(4, 0, 9, 9, 9);
    preload(0, 3, 9, 9, 9);
    for (int l = 0; l < ML; l++)
      for (int r = 0; r < SZ; r++) begin
        weight_rd_layer = l; weight_rd_row = r; #1;
        total++;
        if (weight_rd_data !== exp_row(l, r)) begin
          bad++;
          $display("FAIL dropped_load_bank L%0dR%0d got=%h want=%h", l, r, weight_rd_data,
                   exp_row(l, r));
        end
      end
    weight_rd_layer = 0; weight_rd_row = 3; #1;
    total++;
    if (weight_rd_data !== 48'd0) begin
      bad++;
      $display("FAIL read_row3 got=%h want=0", weight_rd_data);
    end
    weight_rd_layer = 5; weight_rd_row = 0; #1;
    total++;
    if (weight_rd_data !== 48'd0) begin
      bad++;
      $display("FAIL read_layer5 got=%h want=0", weight_rd_data);
    end
  endtask

  task automatic test_reset_mid_pass();
    bit seen;
    int done_cnt;
    do_reset();
    preload(0, 0, 5 * ONE, 5 * ONE, 5 * ONE);
    preload(1, 1, 6 * ONE, 6 * ONE, 6 * ONE);
    grad[1][1][0] = ONE;
    @(negedge clk);
    start = 1'b1; num_layers = 2; learning_rate = 16'(ONE);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (cal_dc_dw === 1'b1 && dc_dw_layer == 1 && dc_dw_row == 1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL midpass_req11 got=not_seen want=seen");
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, cal_dc_dw} !== 3'b000 || dc_dw_layer !== 32'd0 || dc_dw_row !== 32'd0)
    begin
      bad++;
      $display("FAIL midpass_reset_out got=%b(%0d,%0d) want=000(0,0)",
               {busy, done, cal_dc_dw}, dc_dw_layer, dc_dw_row);
    end
    reset = 1'b0;
    model_clear();
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    total++;
    if (done_cnt != 0) begin
      bad++;
      $display("FAIL midpass_no_done got=%0d want=0", done_cnt);
    end
    for (int l = 0; l < ML; l++)
      for (int r = 0; r < SZ; r++) begin
        weight_rd_layer = l; weight_rd_row = r; #1;
        total++;
        if (weight_rd_data !== 48'd0) begin
          bad++;
          $display("FAIL midpass_bank L%0dR%0d got=%h want=0", l, r, weight_rd_data);
        end
      end
  endtask

  task automatic test_saturation();
    int k, cc, bc;
    bit ab;
    do_reset();
    preload(0, 0, 32767, 0, -100);
    grad[0][0][0] = -ONE;
    run_pass(1, ONE, 0, k, cc, bc, ab);
    weight_rd_layer = 0; weight_rd_row = 0; #1;
    total++;
    if (weight_rd_data !== tb_pack(32767, 0, -100)) begin
      bad++;
      $display("FAIL sat_pos_max got=%h want=%h", weight_rd_data, tb_pack(32767, 0, -100));
    end
    grad[0][0][0] = 0; grad[0][0][1] = ONE; grad[0][0][2] = ONE;
    run_pass(1, -32768, 0, k, cc, bc, ab);
    weight_rd_layer = 0; weight_rd_row = 0; #1;
    total++;
    if (weight_rd_data !== tb_pack(32767, 32767, 32667)) begin
      bad++;
      $display("FAIL sat_neg_lr got=%h want=%h", weight_rd_data, tb_pack(32767, 32767, 32667));
    end
    total++;
    if (weight_rd_data !== exp_row(0, 0)) begin
      bad++;
      $display("FAIL sat_model got=%h want=%h", weight_rd_data, exp_row(0, 0));
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_row();
    test_two_layers();
    test_layer_bounds();
    test_ignored_inputs();
    test_reset_mid_pass();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
